// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU arbiter slice: data/control widths,
// ALU opcode encodings and the requester identifier used by the round-robin pointer.
package alu_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned OP_W   = 4;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_SLL = 4'b0010;
   localparam logic [3:0] ALU_AND = 4'b0011;

   typedef enum logic {
      REQ0 = 1'b0,
      REQ1 = 1'b1
   } req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, with a last-grant
// pointer that moves only when a grant is actually issued.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] eligible,
   output logic [1:0] grant
);
   import alu_pkg::*;

   req_id_t last_grant;

   // On a tie the requester that was not granted last wins.
   always_comb begin
      grant = '0;
      case (eligible)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (last_grant == REQ1) ? 2'b01 : 2'b10;
         default: grant = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant <= REQ1;
      end else if (grant[0]) begin
         last_grant <= REQ0;
      end else if (grant[1]) begin
         last_grant <= REQ1;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: muxes the granted operands onto
// the ALU and captures its result and zero flag into that requester's response slot.
module alu_arbiter #(
   parameter int unsigned DATA_W = alu_pkg::DATA_W,
   parameter int unsigned OP_W   = alu_pkg::OP_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [OP_W-1:0]   req0_op,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [OP_W-1:0]   req1_op,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [DATA_W-1:0] rsp0_result,
   output logic              rsp0_zero,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp1_result,
   output logic              rsp1_zero,
   output logic [DATA_W-1:0] alu_in_a,
   output logic [DATA_W-1:0] alu_in_b,
   output logic [OP_W-1:0]   alu_cont,
   input  logic [DATA_W-1:0] alu_output,
   input  logic              alu_zero
);
   import alu_pkg::*;

   logic [1:0] slot_free;
   logic [1:0] eligible;
   logic [1:0] grant;

   // A slot draining this cycle can accept a new result in the same cycle.
   assign slot_free = {~rsp1_valid | rsp1_ready, ~rsp0_valid | rsp0_ready};
   assign eligible  = {2{rst_n}} & {req1_valid, req0_valid} & slot_free;

   rr_arb2 u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .eligible (eligible),
      .grant    (grant)
   );

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];

   always_comb begin
      alu_in_a = '0;
      alu_in_b = '0;
      alu_cont = '0;
      if (grant[0]) begin
         alu_in_a = req0_a;
         alu_in_b = req0_b;
         alu_cont = req0_op;
      end else if (grant[1]) begin
         alu_in_a = req1_a;
         alu_in_b = req1_b;
         alu_cont = req1_op;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp0_valid  <= 1'b0;
         rsp0_result <= '0;
         rsp0_zero   <= 1'b0;
         rsp1_valid  <= 1'b0;
         rsp1_result <= '0;
         rsp1_zero   <= 1'b0;
      end else begin
         if (grant[0]) begin
            rsp0_valid  <= 1'b1;
            rsp0_result <= alu_output;
            rsp0_zero   <= alu_zero;
         end else if (rsp0_ready) begin
            rsp0_valid  <= 1'b0;
         end
         if (grant[1]) begin
            rsp1_valid  <= 1'b1;
            rsp1_result <= alu_output;
            rsp1_zero   <= alu_zero;
         end else if (rsp1_ready) begin
            rsp1_valid  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a behavioural ALU closes the loop, expected
// responses are queued at issue and checked by a monitor whenever a response is consumed.
module tb_alu_arbiter;

   logic        clk;
   logic        rst_n;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [3:0]  req0_op, req1_op;
   logic [15:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_ready, rsp1_ready;
   logic [15:0] rsp0_result, rsp1_result;
   logic        rsp0_zero, rsp1_zero;
   logic [15:0] alu_in_a, alu_in_b;
   logic [3:0]  alu_cont;
   logic [15:0] alu_output;
   logic        alu_zero;

   typedef struct packed {
      logic [15:0] res;
      logic        z;
   } rsp_t;

   rsp_t q0[$];
   rsp_t q1[$];

   int total = 0;
   int bad   = 0;

   alu_arbiter #(.DATA_W(16), .OP_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
      .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_cont(alu_cont),
      .alu_output(alu_output), .alu_zero(alu_zero)
   );

   // External ALU as the parent would provide it.
   always_comb begin
      case (alu_cont)
         4'd0:    alu_output = alu_in_a + alu_in_b;
         4'd1:    alu_output = alu_in_a - alu_in_b;
         4'd2:    alu_output = alu_in_b << alu_in_a[3:0];
         4'd3:    alu_output = alu_in_a & alu_in_b;
         default: alu_output = 16'd0;
      endcase
   end
   assign alu_zero = (alu_output == 16'd0);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic sample(input logic e0, input logic e1, input string name);
      @(negedge clk);
      chk({name, "_req0_ready"}, {31'd0, req0_ready}, {31'd0, e0});
      chk({name, "_req1_ready"}, {31'd0, req1_ready}, {31'd0, e1});
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic push0(input logic [15:0] r, input logic z);
      rsp_t e;
      e.res = r;
      e.z   = z;
      q0.push_back(e);
   endtask

   task automatic push1(input logic [15:0] r, input logic z);
      rsp_t e;
      e.res = r;
      e.z   = z;
      q1.push_back(e);
   endtask

   // Monitor: every consumed response is compared against the head of its queue.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (rsp0_valid && rsp0_ready) begin
            if (q0.size() == 0) begin
               chk("rsp0_unexpected", 32'd1, 32'd0);
            end else begin
               rsp_t e0;
               e0 = q0.pop_front();
               chk("rsp0_result", {16'd0, rsp0_result}, {16'd0, e0.res});
               chk("rsp0_zero", {31'd0, rsp0_zero}, {31'd0, e0.z});
            end
         end
         if (rsp1_valid && rsp1_ready) begin
            if (q1.size() == 0) begin
               chk("rsp1_unexpected", 32'd1, 32'd0);
            end else begin
               rsp_t e1;
               e1 = q1.pop_front();
               chk("rsp1_result", {16'd0, rsp1_result}, {16'd0, e1.res});
               chk("rsp1_zero", {31'd0, rsp1_zero}, {31'd0, e1.z});
            end
         end
      end
   end

   logic [15:0] hold_b   [3];
   logic [15:0] hold_res [3];

   initial begin
      int unsigned k0;
      int unsigned k1;
      logic        exp1;

      hold_b[0] = 16'hFFFF; hold_res[0] = 16'hF0F0;
      hold_b[1] = 16'h0F0F; hold_res[1] = 16'h0000;
      hold_b[2] = 16'h1234; hold_res[2] = 16'h1030;

      rst_n = 1'b0;
      req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
      req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      next();

      // Reset: request already presented but must not be granted.
      req0_valid = 1'b1; req0_op = 4'd0; req0_a = 16'd5; req0_b = 16'd7;
      push0(16'd12, 1'b0);
      sample(1'b0, 1'b0, "in_reset");
      chk("reset_alu_a", {16'd0, alu_in_a}, 32'd0);
      chk("reset_alu_b", {16'd0, alu_in_b}, 32'd0);
      chk("reset_alu_cont", {28'd0, alu_cont}, 32'd0);
      chk("reset_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
      chk("reset_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
      chk("reset_rsp0_result", {16'd0, rsp0_result}, 32'd0);
      chk("reset_rsp0_zero", {31'd0, rsp0_zero}, 32'd0);
      next();
      rst_n = 1'b1;

      // Single requester ADD 5+7.
      sample(1'b1, 1'b0, "add0");
      chk("add0_alu_a", {16'd0, alu_in_a}, 32'd5);
      chk("add0_alu_b", {16'd0, alu_in_b}, 32'd7);
      chk("add0_alu_cont", {28'd0, alu_cont}, 32'd0);
      next();
      req0_valid = 1'b0;
      sample(1'b0, 1'b0, "add0_after");
      chk("add0_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
      chk("add0_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
      chk("idle_alu_a", {16'd0, alu_in_a}, 32'd0);
      next();

      // SLL then an undefined opcode.
      req0_valid = 1'b1; req0_op = 4'd2; req0_a = 16'd4; req0_b = 16'h0003;
      push0(16'h0030, 1'b0);
      sample(1'b1, 1'b0, "sll");
      next();
      req0_op = 4'hF; req0_a = 16'd5; req0_b = 16'd6;
      push0(16'h0000, 1'b1);
      sample(1'b1, 1'b0, "op_f");
      next();
      req0_valid = 1'b0;
      sample(1'b0, 1'b0, "op_f_after");
      next();

      // Continuous contention: req0 won last, so req1 leads the alternation.
      k0 = 0; k1 = 0;
      req0_valid = 1'b1; req0_op = 4'd0; req0_a = 16'(k0); req0_b = 16'd100;
      push0(16'(k0 + 100), 1'b0);
      req1_valid = 1'b1; req1_op = 4'd1; req1_a = 16'd50; req1_b = 16'(k1);
      push1(16'(50 - k1), 1'b0);
      for (int c = 0; c < 8; c++) begin
         exp1 = (c % 2 == 0);
         sample(!exp1, exp1, "contend");
         next();
         if (exp1) begin
            k1++;
            if (k1 < 4) begin
               req1_b = 16'(k1);
               push1(16'(50 - k1), 1'b0);
            end else begin
               req1_valid = 1'b0;
            end
         end else begin
            k0++;
            if (k0 < 4) begin
               req0_a = 16'(k0);
               push0(16'(k0 + 100), 1'b0);
            end else begin
               req0_valid = 1'b0;
            end
         end
      end
      sample(1'b0, 1'b0, "contend_done");
      next();

      // Held response on slot 0 blocks only requester 0.
      rsp0_ready = 1'b0;
      req0_valid = 1'b1; req0_op = 4'd0; req0_a = 16'd1; req0_b = 16'd1;
      push0(16'd2, 1'b0);
      sample(1'b1, 1'b0, "hold_first");
      next();
      req0_a = 16'd3; req0_b = 16'd3;
      push0(16'd6, 1'b0);
      for (int j = 0; j < 3; j++) begin
         req1_valid = 1'b1; req1_op = 4'd3; req1_a = 16'hF0F0; req1_b = hold_b[j];
         push1(hold_res[j], hold_res[j] == 16'd0);
         sample(1'b0, 1'b1, "hold_blocked");
         next();
      end
      req1_valid = 1'b0;
      rsp0_ready = 1'b1;
      sample(1'b1, 1'b0, "hold_release");
      next();
      req0_valid = 1'b0;
      sample(1'b0, 1'b0, "overwrite");
      chk("overwrite_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
      next();

      // Reset while slot 1 holds a result and req1 is waiting.
      rsp1_ready = 1'b0;
      req1_valid = 1'b1; req1_op = 4'd3; req1_a = 16'hFFFF; req1_b = 16'h1234;
      push1(16'h1234, 1'b0);
      sample(1'b0, 1'b1, "pre_reset");
      next();
      req1_op = 4'd0; req1_a = 16'd1; req1_b = 16'd1;
      rst_n = 1'b0;
      sample(1'b0, 1'b0, "mid_reset");
      chk("mid_reset_alu_a", {16'd0, alu_in_a}, 32'd0);
      next();
      q1.delete();
      rst_n = 1'b1;
      rsp1_ready = 1'b1;
      req0_valid = 1'b1; req0_op = 4'd1; req0_a = 16'd9; req0_b = 16'd9;
      push0(16'd0, 1'b1);
      req1_valid = 1'b1; req1_op = 4'd3; req1_a = 16'hF0F0; req1_b = 16'h0FF0;
      push1(16'h00F0, 1'b0);
      sample(1'b1, 1'b0, "tie_first");
      chk("post_reset_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
      next();
      req0_valid = 1'b0;
      sample(1'b0, 1'b1, "tie_second");
      next();
      req1_valid = 1'b0;
      sample(1'b0, 1'b0, "tie_done");
      next();
      next();
      next();

      chk("q0_drained", q0.size(), 32'd0);
      chk("q1_drained", q1.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
